// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: write-through store buffer between the data cache and data memory.
// Coalesces same-address stores, snoops loads, and drains one write at a time.
module dmem_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hit,
    output logic [DATA_W-1:0] ld_data,
    input  logic              drain_hold,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic [15:0]       drained_cnt,
    output logic [15:0]       coalesced_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] mwdata_q, mwdata_d;
    logic [15:0]       drained_q, drained_d;
    logic [15:0]       coal_q, coal_d;

    logic              push;
    logic              push_new;
    logic              pop;
    logic              co_hit;
    logic [PTR_W-1:0]  co_idx;
    logic              sn_hit;
    logic [PTR_W-1:0]  sn_idx;
    logic [PTR_W-1:0]  scan_idx;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign st_ready = !full;
    assign count    = count_q;

    assign mem_we        = (state_q == WRITE);
    assign mem_addr      = maddr_q;
    assign mem_wdata     = mwdata_q;
    assign drained_cnt   = drained_q;
    assign coalesced_cnt = coal_q;

    assign push     = st_valid && st_ready;
    assign push_new = push && !co_hit;

    assign ld_hit  = sn_hit;
    assign ld_data = sn_hit ? data_q[sn_idx] : '0;

    // Oldest-to-youngest scan so the last match found is the youngest one.
    // The in-flight head is frozen, so it is no coalescing target in WRITE.
    always_comb begin
        co_hit   = 1'b0;
        co_idx   = '0;
        sn_hit   = 1'b0;
        sn_idx   = '0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PTR_W'(i);
            if (valid_q[scan_idx]) begin
                if (addr_q[scan_idx] == ld_addr) begin
                    sn_hit = 1'b1;
                    sn_idx = scan_idx;
                end
                if (addr_q[scan_idx] == st_addr &&
                    !(state_q == WRITE && scan_idx == head_q)) begin
                    co_hit = 1'b1;
                    co_idx = scan_idx;
                end
            end
        end
    end

    // Drain FSM next state plus pointer, count and statistics update.
    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        tail_d    = tail_q;
        valid_d   = valid_q;
        maddr_d   = maddr_q;
        mwdata_d  = mwdata_q;
        drained_d = drained_q;
        coal_d    = coal_q;
        pop       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!empty && !drain_hold) begin
                    state_d = WRITE;
                    maddr_d = addr_q[head_q];
                    // A store merging into the head this cycle must not be lost.
                    if (push && co_hit && co_idx == head_q) begin
                        mwdata_d = st_data;
                    end else begin
                        mwdata_d = data_q[head_q];
                    end
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    pop     = 1'b1;
                end
            end
        endcase

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
            drained_d       = drained_q + 16'd1;
        end

        if (push_new) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end

        if (push && co_hit) begin
            coal_d = coal_q + 16'd1;
        end

        count_d = count_q
                + {{(CNT_W-1){1'b0}}, push_new}
                - {{(CNT_W-1){1'b0}}, pop};
    end

    // Control state: FSM, pointers, occupancy, memory port and stats.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            valid_q   <= '0;
            maddr_q   <= '0;
            mwdata_q  <= '0;
            drained_q <= '0;
            coal_q    <= '0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            maddr_q   <= maddr_d;
            mwdata_q  <= mwdata_d;
            drained_q <= drained_d;
            coal_q    <= coal_d;
        end
    end

    // Entry payload: merge into the matching entry or append at tail.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (push) begin
            if (co_hit) begin
                data_q[co_idx] <= st_data;
            end else begin
                addr_q[tail_q] <= st_addr;
                data_q[tail_q] <= st_data;
            end
        end
    end

endmodule
